// File: rtl/rc4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rc4_pkg
// Description : Shared types, constants and helpers for the RC4 key search.
// Revision    : 1.0
// ============================================================================
package rc4_pkg;

    localparam int DEF_MSG_DEP   = 32;
    localparam int DEF_MSG_WIDTH = 8;
    localparam int DEF_KEY_WIDTH = 24;

    localparam logic [7:0] CHAR_LO = 8'h61;
    localparam logic [7:0] CHAR_HI = 8'h7A;
    localparam logic [7:0] CHAR_SP = 8'h20;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_RST_ENG  = 4'd1,
        ST_RUN_INIT = 4'd2,
        ST_RUN_SHUF = 4'd3,
        ST_RUN_DEC  = 4'd4,
        ST_CHECK    = 4'd5,
        ST_NEXT_KEY = 4'd6,
        ST_FOUND    = 4'd7,
        ST_FAIL     = 4'd8
    } state_e;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_INIT = 2'd1,
        SEL_SHUF = 2'd2,
        SEL_DEC  = 2'd3
    } mux_sel_e;

    // Plaintext is accepted only as lowercase letters and spaces.
    function automatic logic is_valid_char(input logic [7:0] c);
        return ((c >= CHAR_LO) && (c <= CHAR_HI)) || (c == CHAR_SP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rc4_key_search_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : rc4_key_search_ctrl_if
// Description : Controller <-> phase-engine / S-memory / host signal bundle.
// Revision    : 1.0
// ============================================================================
interface rc4_key_search_ctrl_if
    import rc4_pkg::*;
#(
    parameter int MSG_DEP   = DEF_MSG_DEP,
    parameter int MSG_WIDTH = DEF_MSG_WIDTH,
    parameter int KEY_WIDTH = DEF_KEY_WIDTH
) ();

    logic                                 start;
    logic                                 busy;
    logic                                 found;
    logic                                 fail;
    logic [KEY_WIDTH-1:0]                 key_out;
    logic                                 eng_reset;

    logic                                 init_start;
    logic                                 shuffle_start;
    logic                                 decrypt_start;
    logic                                 init_done;
    logic                                 shuffle_done;
    logic                                 decrypt_done;

    logic [7:0]                           init_addr;
    logic [7:0]                           shuffle_addr;
    logic [7:0]                           decrypt_addr;
    logic [MSG_WIDTH-1:0]                 init_data;
    logic [MSG_WIDTH-1:0]                 shuffle_data;
    logic [MSG_WIDTH-1:0]                 decrypt_data;
    logic                                 init_we;
    logic                                 shuffle_we;
    logic                                 decrypt_we;

    logic [7:0]                           mem_addr;
    logic [MSG_WIDTH-1:0]                 mem_data;
    logic                                 mem_we;

    logic [MSG_DEP-1:0][MSG_WIDTH-1:0]    decrypted_input;

    modport master (
        input  start, init_done, shuffle_done, decrypt_done,
               init_addr, shuffle_addr, decrypt_addr,
               init_data, shuffle_data, decrypt_data,
               init_we, shuffle_we, decrypt_we, decrypted_input,
        output busy, found, fail, key_out, eng_reset,
               init_start, shuffle_start, decrypt_start,
               mem_addr, mem_data, mem_we
    );

    modport slave (
        output start, init_done, shuffle_done, decrypt_done,
               init_addr, shuffle_addr, decrypt_addr,
               init_data, shuffle_data, decrypt_data,
               init_we, shuffle_we, decrypt_we, decrypted_input,
        input  busy, found, fail, key_out, eng_reset,
               init_start, shuffle_start, decrypt_start,
               mem_addr, mem_data, mem_we
    );

endinterface
`default_nettype wire

// File: rtl/rc4_mem_port_mux.sv
`default_nettype none
// ============================================================================
// Module      : rc4_mem_port_mux
// Description : 3-to-1 S-memory write-port mux; all-zero output when unselected.
// Revision    : 1.0
// ============================================================================
module rc4_mem_port_mux
    import rc4_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  mux_sel_e                    sel_i,
    input  logic [2:0][ADDR_WIDTH-1:0]  addr_i,
    input  logic [2:0][DATA_WIDTH-1:0]  data_i,
    input  logic [2:0]                  we_i,
    output logic [ADDR_WIDTH-1:0]       addr_o,
    output logic [DATA_WIDTH-1:0]       data_o,
    output logic                        we_o
);

    always_comb begin
        addr_o = '0;
        data_o = '0;
        we_o   = 1'b0;
        case (sel_i)
            SEL_INIT: begin
                addr_o = addr_i[0];
                data_o = data_i[0];
                we_o   = we_i[0];
            end
            SEL_SHUF: begin
                addr_o = addr_i[1];
                data_o = data_i[1];
                we_o   = we_i[1];
            end
            SEL_DEC: begin
                addr_o = addr_i[2];
                data_o = data_i[2];
                we_o   = we_i[2];
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rc4_key_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rc4_key_search_ctrl
// Description : Per-key sequencer (init/shuffle/decrypt), plaintext check and
//               key advance; owns the shared S-memory write port.
// Revision    : 1.0
// ============================================================================
module rc4_key_search_ctrl
    import rc4_pkg::*;
#(
    parameter int                 MSG_DEP   = DEF_MSG_DEP,
    parameter int                 MSG_WIDTH = DEF_MSG_WIDTH,
    parameter int                 KEY_WIDTH = DEF_KEY_WIDTH,
    parameter logic [KEY_WIDTH-1:0] KEY_FIRST = 24'h000000,
    parameter logic [KEY_WIDTH-1:0] KEY_LAST  = 24'h3FFFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    rc4_key_search_ctrl_if.master bus
);

    localparam int              K_W    = (MSG_DEP > 1) ? $clog2(MSG_DEP) : 1;
    localparam logic [K_W-1:0]  K_LAST = K_W'(MSG_DEP - 1);

    state_e                 state_q, state_d;
    logic [KEY_WIDTH-1:0]   key_q, key_d;
    logic [K_W-1:0]         k_q, k_d;
    logic                   found_q, found_d;
    logic                   fail_q, fail_d;

    logic [MSG_WIDTH-1:0]   cur_byte;
    mux_sel_e               mux_sel;

    assign cur_byte = bus.decrypted_input[k_q];

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            key_q   <= KEY_FIRST;
            k_q     <= '0;
            found_q <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            k_q     <= k_d;
            found_q <= found_d;
            fail_q  <= fail_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        k_d     = '0;
        found_d = found_q;
        fail_d  = fail_q;
        case (state_q)
            ST_IDLE, ST_FOUND, ST_FAIL: begin
                if (bus.start) begin
                    key_d   = KEY_FIRST;
                    found_d = 1'b0;
                    fail_d  = 1'b0;
                    state_d = ST_RST_ENG;
                end
            end
            ST_RST_ENG:  state_d = ST_RUN_INIT;
            ST_RUN_INIT: if (bus.init_done)    state_d = ST_RUN_SHUF;
            ST_RUN_SHUF: if (bus.shuffle_done) state_d = ST_RUN_DEC;
            ST_RUN_DEC:  if (bus.decrypt_done) state_d = ST_CHECK;
            ST_CHECK: begin
                // k only advances while every byte seen so far is printable
                if (!is_valid_char(cur_byte[7:0])) begin
                    state_d = ST_NEXT_KEY;
                end else if (k_q == K_LAST) begin
                    state_d = ST_FOUND;
                    found_d = 1'b1;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            ST_NEXT_KEY: begin
                if (key_q == KEY_LAST) begin
                    state_d = ST_FAIL;
                    fail_d  = 1'b1;
                end else begin
                    key_d   = key_q + KEY_WIDTH'(1);
                    state_d = ST_RST_ENG;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        bus.busy          = 1'b1;
        bus.eng_reset     = reset;
        bus.init_start    = 1'b0;
        bus.shuffle_start = 1'b0;
        bus.decrypt_start = 1'b0;
        mux_sel           = SEL_NONE;
        case (state_q)
            ST_IDLE: begin
                bus.busy      = 1'b0;
                bus.eng_reset = 1'b1;
            end
            ST_FOUND, ST_FAIL: bus.busy = 1'b0;
            ST_RST_ENG:        bus.eng_reset = 1'b1;
            ST_RUN_INIT: begin
                bus.init_start = 1'b1;
                mux_sel        = SEL_INIT;
            end
            ST_RUN_SHUF: begin
                bus.shuffle_start = 1'b1;
                mux_sel           = SEL_SHUF;
            end
            ST_RUN_DEC: begin
                bus.decrypt_start = 1'b1;
                mux_sel           = SEL_DEC;
            end
            default: ;
        endcase
    end

    assign bus.key_out = key_q;
    assign bus.found   = found_q;
    assign bus.fail    = fail_q;

    rc4_mem_port_mux #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (MSG_WIDTH)
    ) u_mem_mux (
        .sel_i  (mux_sel),
        .addr_i ({bus.decrypt_addr, bus.shuffle_addr, bus.init_addr}),
        .data_i ({bus.decrypt_data, bus.shuffle_data, bus.init_data}),
        .we_i   ({bus.decrypt_we,   bus.shuffle_we,   bus.init_we}),
        .addr_o (bus.mem_addr),
        .data_o (bus.mem_data),
        .we_o   (bus.mem_we)
    );

endmodule
`default_nettype wire

// File: tb/tb_rc4_key_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rc4_key_search_ctrl
// Description : Directed self-checking bench for the RC4 key-search sequencer.
// Revision    : 1.0
// ============================================================================
module tb_rc4_key_search_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rc4_key_search_ctrl_if #(.MSG_DEP(32), .MSG_WIDTH(8), .KEY_WIDTH(24)) bus ();
    rc4_key_search_ctrl_if #(.MSG_DEP(32), .MSG_WIDTH(8), .KEY_WIDTH(24)) bus_hi ();

    rc4_key_search_ctrl #(
        .MSG_DEP(32), .MSG_WIDTH(8), .KEY_WIDTH(24),
        .KEY_FIRST(24'h000000), .KEY_LAST(24'h3FFFFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    rc4_key_search_ctrl #(
        .MSG_DEP(32), .MSG_WIDTH(8), .KEY_WIDTH(24),
        .KEY_FIRST(24'h3FFFFE), .KEY_LAST(24'h3FFFFF)
    ) dut_hi (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_hi)
    );

    int n_total = 0;
    int n_pass  = 0;
    int rst_cnt = 0;
    int mode    = 0;
    logic force_shuf = 1'b0;

    // Engine models: done (sticky) three cycles after start, cleared by eng_reset
    logic [2:0] eng_start_w;
    logic [2:0] eng_done_q;
    logic [1:0] eng_cnt_q [3];
    assign eng_start_w = {bus.decrypt_start, bus.shuffle_start, bus.init_start};

    always @(posedge clk) begin
        for (int e = 0; e < 3; e++) begin
            if (bus.eng_reset) begin
                eng_cnt_q[e]  <= 2'd0;
                eng_done_q[e] <= 1'b0;
            end else if (eng_start_w[e] && !eng_done_q[e]) begin
                if (eng_cnt_q[e] == 2'd2) eng_done_q[e] <= 1'b1;
                eng_cnt_q[e] <= eng_cnt_q[e] + 2'd1;
            end
        end
    end

    assign bus.init_done    = eng_done_q[0];
    assign bus.shuffle_done = eng_done_q[1] | force_shuf;
    assign bus.decrypt_done = eng_done_q[2];
    assign bus.init_addr    = 8'h11;
    assign bus.shuffle_addr = 8'h22;
    assign bus.decrypt_addr = 8'h33;
    assign bus.init_data    = 8'hA1;
    assign bus.shuffle_data = 8'hB2;
    assign bus.decrypt_data = 8'hC3;
    assign bus.init_we      = 1'b1;
    assign bus.shuffle_we   = 1'b1;
    assign bus.decrypt_we   = 1'b1;

    always_comb begin
        bus.decrypted_input = {32{8'h61}};
        case (mode)
            1: begin
                if (bus.key_out >= 24'h000005) bus.decrypted_input = {32{8'h20}};
                else                           bus.decrypted_input[0] = 8'h00;
            end
            2: bus.decrypted_input = '0;
            default: ;
        endcase
    end

    // Second instance: engines finish the cycle they are started
    assign bus_hi.init_done       = bus_hi.init_start;
    assign bus_hi.shuffle_done    = bus_hi.shuffle_start;
    assign bus_hi.decrypt_done    = bus_hi.decrypt_start;
    assign bus_hi.init_addr       = 8'h00;
    assign bus_hi.shuffle_addr    = 8'h00;
    assign bus_hi.decrypt_addr    = 8'h00;
    assign bus_hi.init_data       = 8'h00;
    assign bus_hi.shuffle_data    = 8'h00;
    assign bus_hi.decrypt_data    = 8'h00;
    assign bus_hi.init_we         = 1'b0;
    assign bus_hi.shuffle_we      = 1'b0;
    assign bus_hi.decrypt_we      = 1'b0;
    assign bus_hi.decrypted_input = '0;

    always @(negedge clk) begin
        if (bus.eng_reset && bus.busy) rst_cnt = rst_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.start    = 1'b0;
        bus_hi.start = 1'b0;
        reset        = 1'b1;
        repeat (3) tick();
        chk("rst_busy",      32'(bus.busy),       32'd0);
        chk("rst_found",     32'(bus.found),      32'd0);
        chk("rst_fail",      32'(bus.fail),       32'd0);
        chk("rst_key",       32'(bus.key_out),    32'h000000);
        chk("rst_eng_reset", 32'(bus.eng_reset),  32'd1);
        chk("rst_init_start",32'(bus.init_start), 32'd0);
        chk("rst_mem_we",    32'(bus.mem_we),     32'd0);
        chk("rst_hi_key",    32'(bus_hi.key_out), 32'h3FFFFE);
        reset = 1'b0;
        tick();
        chk("idle_eng_reset", 32'(bus.eng_reset), 32'd1);

        // Key 0 decrypts to all 'a': walk every phase with exact timing
        mode = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("t1_busy",       32'(bus.busy),       32'd1);
        chk("t1_rst_eng",    32'(bus.eng_reset),  32'd1);
        chk("t1_no_init",    32'(bus.init_start), 32'd0);
        chk("t1_rsteng_we",  32'(bus.mem_we),     32'd0);
        tick();
        chk("t1_init_start", 32'(bus.init_start), 32'd1);
        chk("t1_init_engrst",32'(bus.eng_reset),  32'd0);
        chk("t1_init_we",    32'(bus.mem_we),     32'd1);
        chk("t1_init_addr",  32'(bus.mem_addr),   32'h11);
        chk("t1_init_data",  32'(bus.mem_data),   32'hA1);
        repeat (3) tick();
        chk("t1_init_hold",  32'(bus.init_start), 32'd1);
        tick();
        chk("t1_shuf_start", 32'(bus.shuffle_start), 32'd1);
        chk("t1_init_fall",  32'(bus.init_start),    32'd0);
        chk("t1_shuf_addr",  32'(bus.mem_addr),      32'h22);
        chk("t1_shuf_data",  32'(bus.mem_data),      32'hB2);
        repeat (4) tick();
        chk("t1_dec_start",  32'(bus.decrypt_start), 32'd1);
        chk("t1_dec_addr",   32'(bus.mem_addr),      32'h33);
        chk("t1_dec_data",   32'(bus.mem_data),      32'hC3);
        repeat (4) tick();
        chk("t1_chk_dec",    32'(bus.decrypt_start), 32'd0);
        chk("t1_chk_we",     32'(bus.mem_we),        32'd0);
        chk("t1_chk_addr",   32'(bus.mem_addr),      32'h00);
        chk("t1_chk_busy",   32'(bus.busy),          32'd1);
        repeat (31) tick();
        chk("t1_not_yet",    32'(bus.found),         32'd0);
        tick();
        chk("t1_found",      32'(bus.found),         32'd1);
        chk("t1_key",        32'(bus.key_out),       32'h000000);
        chk("t1_fail",       32'(bus.fail),          32'd0);
        chk("t1_busy_low",   32'(bus.busy),          32'd0);
        chk("t1_found_we",   32'(bus.mem_we),        32'd0);

        // Byte 0 invalid until key 5, then all spaces
        mode = 1;
        rst_cnt = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("t2_found_clr",  32'(bus.found),      32'd0);
        tick();
        force_shuf = 1'b1;
        repeat (2) tick();
        chk("t2_spur_init",  32'(bus.init_start),    32'd1);
        chk("t2_spur_shuf",  32'(bus.shuffle_start), 32'd0);
        force_shuf = 1'b0;
        repeat (10) tick();
        chk("t2_chk_busy",   32'(bus.busy),          32'd1);
        chk("t2_chk_we",     32'(bus.mem_we),        32'd0);
        tick();
        chk("t2_nk_we",      32'(bus.mem_we),        32'd0);
        chk("t2_nk_engrst",  32'(bus.eng_reset),     32'd0);
        chk("t2_nk_key",     32'(bus.key_out),       32'h000000);
        tick();
        chk("t2_rst_eng",    32'(bus.eng_reset),     32'd1);
        chk("t2_key1",       32'(bus.key_out),       32'h000001);
        for (int n = 0; n < 1000 && !bus.found; n++) tick();
        chk("t2_found",      32'(bus.found),         32'd1);
        chk("t2_key",        32'(bus.key_out),       32'h000005);
        chk("t2_fail",       32'(bus.fail),          32'd0);
        chk("t2_rst_pulses", 32'(rst_cnt),           32'd6);

        // Reset while decrypting key 3
        mode = 2;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int n = 0; n < 500 && !(bus.key_out == 24'h000003 && bus.decrypt_start); n++) tick();
        chk("t3_reach_dec",  32'(bus.decrypt_start), 32'd1);
        chk("t3_reach_key",  32'(bus.key_out),       32'h000003);
        reset = 1'b1;
        tick();
        chk("t3_busy",       32'(bus.busy),          32'd0);
        chk("t3_key",        32'(bus.key_out),       32'h000000);
        chk("t3_dec_start",  32'(bus.decrypt_start), 32'd0);
        chk("t3_eng_reset",  32'(bus.eng_reset),     32'd1);
        reset = 1'b0;
        tick();
        chk("t3_idle_busy",  32'(bus.busy),          32'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("t3_restart",    32'(bus.busy),          32'd1);
        chk("t3_restart_key",32'(bus.key_out),       32'h000000);
        tick();
        chk("t3_init_start", 32'(bus.init_start),    32'd1);

        // Range exhaustion at the top of the key space
        bus_hi.start = 1'b1;
        tick();
        bus_hi.start = 1'b0;
        for (int n = 0; n < 200 && !bus_hi.fail; n++) tick();
        chk("t4_fail",       32'(bus_hi.fail),       32'd1);
        chk("t4_key",        32'(bus_hi.key_out),    32'h3FFFFF);
        chk("t4_found",      32'(bus_hi.found),      32'd0);
        chk("t4_busy",       32'(bus_hi.busy),       32'd0);
        repeat (5) tick();
        chk("t4_no_wrap",    32'(bus_hi.key_out),    32'h3FFFFF);
        chk("t4_fail_hold",  32'(bus_hi.fail),       32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
